// File: rtl/voice_match_sched.sv
// Template search sequencer: streams the sample buffer against every directory template,
// scores each word pair with a per-byte threshold compare and reports the best template.
module voice_match_sched #(
    parameter int unsigned N_WORDS     = 256,
    parameter int unsigned N_TEMPLATES = 4,
    parameter int unsigned MIN_SCORE   = 512,
    parameter int unsigned SCORE_W     = $clog2(4 * N_WORDS + 1),
    parameter int unsigned TIDX_W      = (N_TEMPLATES > 1) ? $clog2(N_TEMPLATES) : 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_l,
    input  logic                                   i_start,
    input  logic                                   i_abort,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_ram_rd,
    output logic [$clog2(N_WORDS)-1:0]             o_ram_addr,
    input  logic [31:0]                            i_ram_data,
    output logic                                   o_dir_rd,
    output logic [$clog2(N_WORDS*N_TEMPLATES)-1:0] o_dir_addr,
    input  logic [31:0]                            i_dir_data,
    output logic [TIDX_W-1:0]                      o_best_idx,
    output logic [SCORE_W-1:0]                     o_best_score,
    output logic                                   o_match
);

    localparam int unsigned AW     = $clog2(N_WORDS);
    localparam int unsigned DIR_AW = $clog2(N_WORDS * N_TEMPLATES);
    localparam int unsigned CAT_W  = AW + TIDX_W;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StEval, StDone} state_t;

    state_t              r_state;
    logic [AW-1:0]       r_w;
    logic [TIDX_W-1:0]   r_t;
    logic [SCORE_W-1:0]  r_acc;
    logic [TIDX_W-1:0]   r_best_idx;
    logic [SCORE_W-1:0]  r_best_score;
    logic [TIDX_W-1:0]   r_res_idx;
    logic [SCORE_W-1:0]  r_res_score;
    logic                r_res_match;
    logic                r_done;

    logic [7:0]          w_diff [4];
    logic [3:0]          w_hit;
    logic [2:0]          w_cmp;
    logic                w_last_w;
    logic                w_last_t;
    logic [CAT_W-1:0]    w_cat_addr;

    // Byte-threshold compare: count bytes whose absolute difference is at most 15.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_diff[i] = (i_ram_data[8*i +: 8] >= i_dir_data[8*i +: 8])
                      ? (i_ram_data[8*i +: 8] - i_dir_data[8*i +: 8])
                      : (i_dir_data[8*i +: 8] - i_ram_data[8*i +: 8]);
            w_hit[i]  = (w_diff[i] <= 8'd15);
        end
        w_cmp = 3'(w_hit[0]) + 3'(w_hit[1]) + 3'(w_hit[2]) + 3'(w_hit[3]);
    end

    assign w_last_w   = (r_w == AW'(N_WORDS - 1));
    assign w_last_t   = (r_t == TIDX_W'(N_TEMPLATES - 1));
    // N_WORDS is a power of two, so template*N_WORDS + word is a plain concatenation.
    assign w_cat_addr = {r_t, r_w};

    assign o_busy       = (r_state != StIdle);
    assign o_ram_rd     = (r_state == StRun);
    assign o_dir_rd     = (r_state == StRun);
    assign o_ram_addr   = r_w;
    assign o_dir_addr   = w_cat_addr[DIR_AW-1:0];
    assign o_done       = r_done;
    assign o_best_idx   = r_res_idx;
    assign o_best_score = r_res_score;
    assign o_match      = r_res_match;

    // Search FSM with counters, accumulator, running best and registered results.
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state      <= StIdle;
            r_w          <= '0;
            r_t          <= '0;
            r_acc        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_res_idx    <= '0;
            r_res_score  <= '0;
            r_res_match  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && (r_state != StIdle)) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_state <= StRun;
                            r_t     <= '0;
                            r_w     <= '0;
                            r_acc   <= '0;
                        end
                    end
                    StRun: begin
                        // Data returned in the first RUN cycle is stale; skip it.
                        if (r_w != '0) begin
                            r_acc <= r_acc + SCORE_W'(w_cmp);
                        end
                        r_w <= r_w + 1'b1;
                        if (w_last_w) begin
                            r_state <= StDrain;
                        end
                    end
                    StDrain: begin
                        r_acc   <= r_acc + SCORE_W'(w_cmp);
                        r_state <= StEval;
                    end
                    StEval: begin
                        // Strict compare so ties keep the lower template index.
                        if ((r_t == '0) || (r_acc > r_best_score)) begin
                            r_best_idx   <= r_t;
                            r_best_score <= r_acc;
                        end
                        if (w_last_t) begin
                            r_state <= StDone;
                        end else begin
                            r_t     <= r_t + 1'b1;
                            r_w     <= '0;
                            r_acc   <= '0;
                            r_state <= StRun;
                        end
                    end
                    StDone: begin
                        r_done      <= 1'b1;
                        r_res_idx   <= r_best_idx;
                        r_res_score <= r_best_score;
                        r_res_match <= (32'(r_best_score) >= MIN_SCORE);
                        r_state     <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_match_sched.sv
// Directed bench for voice_match_sched with 1-cycle-latency sample and directory memories.
module tb_voice_match_sched;

    logic        clk;
    logic        rst_l;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        ram_rd;
    logic [1:0]  ram_addr;
    logic [31:0] ram_data;
    logic        dir_rd;
    logic [3:0]  dir_addr;
    logic [31:0] dir_data;
    logic [1:0]  best_idx;
    logic [4:0]  best_score;
    logic        match;

    logic [31:0] ram_mem [4];
    logic [31:0] dir_mem [12];

    int n_total;
    int n_bad;

    voice_match_sched #(
        .N_WORDS     (4),
        .N_TEMPLATES (3),
        .MIN_SCORE   (10)
    ) dut (
        .i_clk        (clk),
        .i_rst_l      (rst_l),
        .i_start      (start),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .o_ram_rd     (ram_rd),
        .o_ram_addr   (ram_addr),
        .i_ram_data   (ram_data),
        .o_dir_rd     (dir_rd),
        .o_dir_addr   (dir_addr),
        .i_dir_data   (dir_data),
        .o_best_idx   (best_idx),
        .o_best_score (best_score),
        .o_match      (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory models.
    always @(posedge clk) begin
        if (ram_rd) ram_data <= ram_mem[ram_addr];
        if (dir_rd) dir_data <= dir_mem[dir_addr];
    end

    // Scenario 1: template 1 identical, others far; 2: threshold boundary; 3: every template 5.
    task automatic load_data(input int scen);
        for (int w = 0; w < 4; w++) begin
            case (scen)
                1: begin
                    ram_mem[w]   = 32'h40404040;
                    dir_mem[w]   = 32'hC0C0C0C0;
                    dir_mem[4+w] = 32'h40404040;
                    dir_mem[8+w] = 32'hC0C0C0C0;
                end
                2: begin
                    ram_mem[w]   = 32'h10101010;
                    dir_mem[w]   = 32'h1F1F1F1F;
                    dir_mem[4+w] = 32'h20202020;
                    dir_mem[8+w] = 32'h01010101;
                end
                default: begin
                    ram_mem[w] = 32'h10101010;
                    for (int t = 0; t < 3; t++) begin
                        dir_mem[4*t+w] = (w == 0) ? 32'h10101010 :
                                         (w == 1) ? 32'h10808080 : 32'h80808080;
                    end
                end
            endcase
        end
    endtask

    // Pulse start and report the first done cycle (0 if none within 40) and the done count.
    task automatic run_search(output int done_cyc, output int done_cnt);
        done_cyc = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #12;
        n_total++;
        if ({busy, done, ram_rd, dir_rd, match, best_idx, best_score} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {busy, done, ram_rd, dir_rd, match, best_idx, best_score});
        end
        rst_l = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int t;
        int p;
        logic exp_rd;
        load_data(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            t = k / 6;
            p = k % 6;
            exp_rd = (k < 18) && (p < 4);
            n_total++;
            if ({ram_rd, dir_rd} !== {exp_rd, exp_rd}) begin
                n_bad++;
                $display("FAIL basic_strobe k=%0d: got %b want %b", k, {ram_rd, dir_rd},
                         {exp_rd, exp_rd});
            end
            if (exp_rd) begin
                n_total++;
                if ((ram_addr !== 2'(p)) || (dir_addr !== 4'(t * 4 + p))) begin
                    n_bad++;
                    $display("FAIL basic_addr k=%0d: got ram=%0d dir=%0d want ram=%0d dir=%0d",
                             k, ram_addr, dir_addr, p, t * 4 + p);
                end
            end
            n_total++;
            if (busy !== (k < 19)) begin
                n_bad++;
                $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, (k < 19));
            end
            n_total++;
            if (done !== (k == 19)) begin
                n_bad++;
                $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == 19));
            end
            if (k == 19) begin
                n_total++;
                if ({best_idx, best_score, match} !== {2'd1, 5'd16, 1'b1}) begin
                    n_bad++;
                    $display("FAIL basic_result: got idx=%0d score=%0d match=%b want 1 16 1",
                             best_idx, best_score, match);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundary();
        int dc;
        int dn;
        load_data(2);
        run_search(dc, dn);
        n_total++;
        if ((dc != 19) || (dn != 1)) begin
            n_bad++;
            $display("FAIL boundary_done: got cycle=%0d count=%0d want 19 1", dc, dn);
        end
        n_total++;
        if ({best_idx, best_score, match} !== {2'd0, 5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL boundary_result: got idx=%0d score=%0d match=%b want 0 16 1",
                     best_idx, best_score, match);
        end
    endtask

    task automatic test_low_score();
        int dc;
        int dn;
        load_data(3);
        run_search(dc, dn);
        n_total++;
        if ((dc != 19) || (dn != 1)) begin
            n_bad++;
            $display("FAIL low_done: got cycle=%0d count=%0d want 19 1", dc, dn);
        end
        n_total++;
        if ({best_idx, best_score, match} !== {2'd0, 5'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL low_result: got idx=%0d score=%0d match=%b want 0 5 0",
                     best_idx, best_score, match);
        end
    endtask

    task automatic test_abort();
        int dc;
        int dn;
        int stray;
        load_data(1);
        run_search(dc, dn);
        n_total++;
        if ({best_idx, best_score, match} !== {2'd1, 5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_first_result: got idx=%0d score=%0d match=%b want 1 16 1",
                     best_idx, best_score, match);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
        end
        // Template 1, second RUN cycle.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_total++;
        if ({busy, ram_rd, dir_rd, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL abort_idle: got busy/rd/rd/done=%b want 0000",
                     {busy, ram_rd, dir_rd, done});
        end
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        n_total++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", stray);
        end
        n_total++;
        if ({best_idx, best_score, match} !== {2'd1, 5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_hold: got idx=%0d score=%0d match=%b want 1 16 1",
                     best_idx, best_score, match);
        end
        load_data(3);
        run_search(dc, dn);
        n_total++;
        if ((dc != 19) || ({best_idx, best_score, match} !== {2'd0, 5'd5, 1'b0})) begin
            n_bad++;
            $display("FAIL abort_restart: got cycle=%0d idx=%0d score=%0d match=%b want 19 0 5 0",
                     dc, best_idx, best_score, match);
        end
    endtask

    task automatic test_start_busy();
        int dc;
        int dn;
        dc = 0;
        dn = 0;
        load_data(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            start = (k < 17) && (k % 2 == 1);
            @(posedge clk); #1;
            if (done) begin
                dn++;
                if (dc == 0) dc = k;
            end
        end
        start = 1'b0;
        n_total++;
        if ((dc != 19) || (dn != 1)) begin
            n_bad++;
            $display("FAIL busy_start_done: got cycle=%0d count=%0d want 19 1", dc, dn);
        end
        n_total++;
        if ({best_idx, best_score, match} !== {2'd0, 5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL busy_start_result: got idx=%0d score=%0d match=%b want 0 16 1",
                     best_idx, best_score, match);
        end
    endtask

    task automatic test_async_reset();
        int dc;
        int dn;
        load_data(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        // Template 1 DRAIN; drop reset between clock edges.
        #2;
        rst_l = 1'b0;
        #1;
        n_total++;
        if ({busy, done, ram_rd, dir_rd, match, best_idx, best_score} !== 11'd0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %b want 0",
                     {busy, done, ram_rd, dir_rd, match, best_idx, best_score});
        end
        #3;
        rst_l = 1'b1;
        @(posedge clk); #1;
        run_search(dc, dn);
        n_total++;
        if ((dc != 19) || (dn != 1)) begin
            n_bad++;
            $display("FAIL async_reset_done: got cycle=%0d count=%0d want 19 1", dc, dn);
        end
        n_total++;
        if ({best_idx, best_score, match} !== {2'd1, 5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset_result: got idx=%0d score=%0d match=%b want 1 16 1",
                     best_idx, best_score, match);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_low_score();
        test_abort();
        test_start_busy();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
